cam_capture: RTL and testbench
==============================

Name: cam_capture

Overview:
- Pixel-capture front end for the OV7670-style parallel camera interface, clocked by the camera pixel clock.
- Aligns to frames with vsync and to lines with href, and extracts the luma (Y) byte of each YUV422 pixel as 8-bit grayscale.
- Presents each pixel with its column/row coordinates for the downstream frame-buffer writer.
- Capture is enabled only after the camera register configuration block reports completion.

Parameters:
- H_ACTIVE, 640, pixels per line; column counter saturates at H_ACTIVE-1.
- V_ACTIVE, 480, lines per frame; row counter saturates at V_ACTIVE-1.
- BYTES_PER_PIXEL, 2, camera bytes per pixel (legal values 1 or 2).
- Y_FIRST, 1, 1: luma is the first byte of each pixel (Y U Y V order); 0: luma is the second byte.

Ports:
- pclk  in  1  camera pixel clock; sole clock.
- reset  in  1  synchronous, active-high reset.
- href  in  1  line-valid from camera; high during active bytes of a line.
- vsync  in  1  frame sync from camera; high between frames.
- cam_data  in  8  camera data byte.
- config_done  in  1  high once camera configuration is complete; level, may drop.
- x_coord  out  10  column of the pixel on pixel_data.
- y_coord  out  10  row of the pixel on pixel_data.
- pixel_data  out  8  captured luma byte.

Interface decision: one clock; reset is synchronous and active-high.

Behaviour:
- Input stage: href, vsync, cam_data registered once on rising pclk (href_q, vsync_q, data_q). All control uses these registered copies; previous-cycle copies provide edge detection.
- Reset (sampled on rising pclk):
  - x_coord=0, y_coord=0, pixel_data=0.
  - col, row, byte-phase counters cleared.
  - Input registers cleared; state=WAIT_CONFIG.
  - Reset overrides all other events.
- WAIT_CONFIG: outputs hold their values; counters held at 0. Go to WAIT_FRAME when config_done=1.
- WAIT_FRAME: discards any partial frame in progress.
  - Go to ACTIVE on the falling edge of vsync_q (1→0).
  - A vsync_q already low on entry must first rise, then fall.
  - Counters cleared.
- ACTIVE:
  - Rising edge of href_q: byte phase cleared to 0.
  - While href_q=1, phase advances modulo BYTES_PER_PIXEL on every cycle.
  - Luma byte is phase 0 when Y_FIRST=1, phase BYTES_PER_PIXEL-1 otherwise.
  - On a luma cycle: pixel_data<=data_q, x_coord<=col, y_coord<=row, then col increments.
  - At col=H_ACTIVE-1 further luma bytes in that line are ignored and outputs hold.
  - Falling edge of href_q: col<=0; row increments, saturating at V_ACTIVE-1 (extra lines ignored).
  - vsync_q=1: go to WAIT_FRAME; outputs hold last values.
- config_done=0 in any state: next state WAIT_CONFIG, counters cleared, outputs hold.
- Latency: a luma byte present on cam_data at rising edge k appears on pixel_data, with its coordinates, after rising edge k+1.
- Outputs change only on luma cycles or reset.
- With the defaults, each line yields 640 pixels, x_coord 0..639, over 1280 pclk.
- Outputs are registered, with no combinational path from inputs.

Test Plan:
- Reset with arbitrary inputs for 3 cycles -> x_coord=0, y_coord=0, pixel_data=0; outputs static while config_done=0, including across a full vsync/href frame.
- config_done=1 at power-up with vsync low and href toggling; lines issued before the first vsync pulse -> no output change. After a vsync high→low, line 0 bytes 0x10,0x80,0x11,0x80 -> pixel_data 0x10 at (0,0), then 0x11 at (1,0), each one pclk after its byte.
- Full line of 1280 bytes, Y values equal to column mod 256, then href low, then a second line -> last pixel of line 0 is (639,0) with 0x7F; first pixel of line 1 is (0,1).
- Line of 1400 bytes -> x_coord stops at 639, pixel_data frozen at the 640th luma value. 482 lines -> y_coord stops at 479.
- vsync raised mid-line 10, then new frame -> first pixel of next frame at (0,0). Same with config_done dropped mid-line -> no capture until config_done=1 and a full vsync pulse.
- Reset asserted mid-line -> outputs 0 next cycle, state WAIT_CONFIG; capture resumes only after config_done=1 and a vsync fall.

Source files
------------

// File: rtl/cam_capture.sv
// OV7670-style parallel camera capture: aligns to vsync/href, extracts the luma byte
// of each YUV422 pixel and presents it with its column/row coordinates.
module cam_capture #(
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter int BYTES_PER_PIXEL = 2,
  parameter int Y_FIRST         = 1
) (
  input  logic       pclk,
  input  logic       reset,
  input  logic       href,
  input  logic       vsync,
  input  logic [7:0] cam_data,
  input  logic       config_done,
  output logic [9:0] x_coord,
  output logic [9:0] y_coord,
  output logic [7:0] pixel_data
);

  typedef enum logic [1:0] {
    WAIT_CONFIG = 2'd0,
    WAIT_FRAME  = 2'd1,
    ACTIVE      = 2'd2
  } state_t;

  localparam logic [0:0] LAST_PHASE = 1'(BYTES_PER_PIXEL - 1);
  localparam logic [0:0] LUMA_PHASE = (Y_FIRST != 0) ? 1'b0 : LAST_PHASE;
  localparam logic [9:0] COL_MAX    = 10'(H_ACTIVE - 1);
  localparam logic [9:0] ROW_MAX    = 10'(V_ACTIVE - 1);

  state_t     state_q;
  logic       href_q;
  logic       vsync_q;
  logic [7:0] data_q;
  logic       href_prev_q;
  logic [0:0] phase_q;
  logic [9:0] col_q;
  logic [9:0] row_q;
  logic       col_full_q;
  logic       row_full_q;
  logic       seen_high_q;
  logic [9:0] x_q;
  logic [9:0] y_q;
  logic [7:0] pix_q;

  logic       href_rise_s;
  logic       href_fall_s;
  logic [0:0] cur_phase_s;
  logic       luma_s;
  logic [0:0] phase_d;

  // Byte-phase tracking: the first byte of a line is always phase 0.
  always_comb begin
    href_rise_s = href_q && !href_prev_q;
    href_fall_s = !href_q && href_prev_q;
    if (href_rise_s) begin
      cur_phase_s = 1'b0;
    end else begin
      cur_phase_s = phase_q;
    end
    luma_s = href_q && (cur_phase_s == LUMA_PHASE);
    if (cur_phase_s == LAST_PHASE) begin
      phase_d = 1'b0;
    end else begin
      phase_d = cur_phase_s + 1'b1;
    end
  end

  // Input stage, frame/line FSM, counters and registered pixel outputs.
  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q     <= WAIT_CONFIG;
      href_q      <= 1'b0;
      vsync_q     <= 1'b0;
      data_q      <= 8'd0;
      href_prev_q <= 1'b0;
      phase_q     <= 1'b0;
      col_q       <= 10'd0;
      row_q       <= 10'd0;
      col_full_q  <= 1'b0;
      row_full_q  <= 1'b0;
      seen_high_q <= 1'b0;
      x_q         <= 10'd0;
      y_q         <= 10'd0;
      pix_q       <= 8'd0;
    end else begin
      href_q      <= href;
      vsync_q     <= vsync;
      data_q      <= cam_data;
      href_prev_q <= href_q;
      if (!config_done) begin
        state_q     <= WAIT_CONFIG;
        phase_q     <= 1'b0;
        col_q       <= 10'd0;
        row_q       <= 10'd0;
        col_full_q  <= 1'b0;
        row_full_q  <= 1'b0;
        seen_high_q <= 1'b0;
      end else begin
        case (state_q)
          WAIT_CONFIG: begin
            state_q     <= WAIT_FRAME;
            phase_q     <= 1'b0;
            col_q       <= 10'd0;
            row_q       <= 10'd0;
            col_full_q  <= 1'b0;
            row_full_q  <= 1'b0;
            seen_high_q <= 1'b0;
          end
          WAIT_FRAME: begin
            phase_q    <= 1'b0;
            col_q      <= 10'd0;
            row_q      <= 10'd0;
            col_full_q <= 1'b0;
            row_full_q <= 1'b0;
            // A frame starts only on a vsync fall observed from within this state.
            if (vsync_q) begin
              seen_high_q <= 1'b1;
            end else if (seen_high_q) begin
              seen_high_q <= 1'b0;
              state_q     <= ACTIVE;
            end else begin
              seen_high_q <= 1'b0;
            end
          end
          ACTIVE: begin
            if (vsync_q) begin
              state_q     <= WAIT_FRAME;
              seen_high_q <= 1'b1;
            end else begin
              if (href_q) begin
                phase_q <= phase_d;
              end else begin
                phase_q <= 1'b0;
              end
              if (luma_s && !col_full_q && !row_full_q) begin
                pix_q <= data_q;
                x_q   <= col_q;
                y_q   <= row_q;
                if (col_q == COL_MAX) begin
                  col_full_q <= 1'b1;
                end else begin
                  col_q <= col_q + 10'd1;
                end
              end
              if (href_fall_s) begin
                col_q      <= 10'd0;
                col_full_q <= 1'b0;
                if (row_q == ROW_MAX) begin
                  row_full_q <= 1'b1;
                end else begin
                  row_q <= row_q + 10'd1;
                end
              end
            end
          end
          default: begin
            state_q <= WAIT_CONFIG;
          end
        endcase
      end
    end
  end

  assign x_coord    = x_q;
  assign y_coord    = y_q;
  assign pixel_data = pix_q;

endmodule

// File: tb/tb_cam_capture.sv
// Randomized scoreboard bench for cam_capture: a line/frame-level reference model
// predicts each captured pixel and the cycle it must appear.
module tb_cam_capture;
  localparam int H = 640;
  localparam int V = 480;

  logic       pclk = 1'b0;
  logic       reset = 1'b1;
  logic       href = 1'b0;
  logic       vsync = 1'b0;
  logic [7:0] cam_data = 8'd0;
  logic       config_done = 1'b0;
  logic [9:0] x_coord;
  logic [9:0] y_coord;
  logic [7:0] pixel_data;

  cam_capture dut (
    .pclk(pclk), .reset(reset), .href(href), .vsync(vsync), .cam_data(cam_data),
    .config_done(config_done), .x_coord(x_coord), .y_coord(y_coord), .pixel_data(pixel_data)
  );

  always #5 pclk = ~pclk;

  typedef struct { int x; int y; int pix; int due; } exp_t;
  exp_t q[$];

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  bit  in_reset = 1'b1;
  bit  armed = 1'b0;
  bit  cfg_ok = 1'b0;
  int  line_idx = 0;
  int  lx = 0, ly = 0, lp = 0;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every change of the output tuple must match the oldest prediction.
  initial begin
    logic [27:0] prev;
    logic [27:0] cur;
    exp_t e;
    prev = 28'd0;
    forever begin
      @(negedge pclk);
      cur = {x_coord, y_coord, pixel_data};
      if (!in_reset && cur != prev) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got (%0d,%0d)=%0d at cycle %0d with nothing predicted",
                   x_coord, y_coord, pixel_data, cyc);
        end else begin
          e = q.pop_front();
          if (int'(x_coord) != e.x || int'(y_coord) != e.y || int'(pixel_data) != e.pix || cyc != e.due) begin
            errors++;
            $display("FAIL pixel: got (%0d,%0d)=%0d at cycle %0d expected (%0d,%0d)=%0d at cycle %0d",
                     x_coord, y_coord, pixel_data, cyc, e.x, e.y, e.pix, e.due);
          end
        end
      end
      prev = cur;
    end
  end

  task automatic set_config(input bit v);
    tick();
    config_done = v;
    cfg_ok = v;
    if (!v) armed = 1'b0;
    repeat (3) tick();
  endtask

  task automatic vsync_pulse();
    tick();
    vsync = 1'b1;
    repeat (4) tick();
    vsync = 1'b0;
    armed = cfg_ok;
    line_idx = 0;
    repeat (3) tick();
  endtask

  // dmode: 0 random, 1 luma = column mod 256, 2 luma 0x10+column / chroma 0x80.
  // cut_mode: 0 none, 1 vsync rises, 2 config_done drops, 3 reset pulse, at byte cut_at.
  // vsync travels with the data through the input stage, but config_done and reset
  // act directly, so they also squash the byte already sitting in the input stage.
  task automatic drive_line(input int nbytes, input int dmode, input int cut_mode, input int cut_at);
    int cutoff;
    logic [7:0] d;
    cutoff = (cut_mode == 0) ? nbytes : ((cut_mode == 1) ? cut_at : cut_at - 1);
    for (int i = 0; i < nbytes; i++) begin
      tick();
      if (i % 2 == 0) begin
        case (dmode)
          1: d = 8'((i / 2) % 256);
          2: d = 8'h10 + 8'(i / 2);
          default: d = 8'($urandom_range(1, 255));
        endcase
      end else begin
        d = (dmode == 2) ? 8'h80 : 8'($urandom_range(0, 255));
      end
      href = 1'b1;
      cam_data = d;
      if (cut_mode != 0 && i == cut_at) begin
        case (cut_mode)
          1: vsync = 1'b1;
          2: begin config_done = 1'b0; cfg_ok = 1'b0; end
          3: reset = 1'b1;
          default: ;
        endcase
      end
      if (cut_mode == 3 && i == cut_at + 1) begin
        reset = 1'b0;
        in_reset = 1'b1;
      end
      if (cut_mode == 3 && i == cut_at + 2) begin
        check("midline_reset_x", int'(x_coord), 0);
        check("midline_reset_y", int'(y_coord), 0);
        check("midline_reset_pix", int'(pixel_data), 0);
        in_reset = 1'b0;
      end
      if (armed && (i % 2 == 0) && (i / 2 < H) && (line_idx < V) && (i < cutoff)) begin
        q.push_back('{x: i / 2, y: line_idx, pix: int'(d), due: cyc + 2});
        lx = i / 2; ly = line_idx; lp = int'(d);
      end
    end
    tick();
    href = 1'b0;
    cam_data = 8'($urandom_range(0, 255));
    repeat (3) tick();
    if (cut_mode == 0) begin
      if (armed) line_idx++;
    end else begin
      armed = 1'b0;
      if (cut_mode == 1) begin
        vsync = 1'b0;
        armed = cfg_ok;
        line_idx = 0;
        repeat (3) tick();
      end
    end
  endtask

  task automatic drain(input string name);
    repeat (4) tick();
    check(name, q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with arbitrary inputs, then a full frame with configuration pending.
    for (int i = 0; i < 3; i++) begin
      tick();
      href = 1'($urandom_range(0, 1));
      vsync = 1'($urandom_range(0, 1));
      cam_data = 8'($urandom_range(0, 255));
      config_done = 1'($urandom_range(0, 1));
    end
    tick();
    reset = 1'b0; href = 1'b0; vsync = 1'b0; config_done = 1'b0;
    tick();
    check("reset_x", int'(x_coord), 0);
    check("reset_y", int'(y_coord), 0);
    check("reset_pix", int'(pixel_data), 0);
    in_reset = 1'b0;
    vsync_pulse();
    for (int l = 0; l < 3; l++) drive_line(20, 0, 0, 0);
    vsync_pulse();
    check("noconfig_pix", int'(pixel_data), 0);
    drain("drain_noconfig");

    // Config done, lines before any vsync pulse are ignored; then line 0 capture.
    set_config(1'b1);
    for (int l = 0; l < 2; l++) drive_line(16, 0, 0, 0);
    vsync_pulse();
    drive_line(4, 2, 0, 0);
    drain("drain_first");
    check("first_x", int'(x_coord), 1);
    check("first_pix", int'(pixel_data), 8'h11);

    // Full-length line followed by a second line.
    vsync_pulse();
    drive_line(2 * H, 1, 0, 0);
    check("fullline_x", int'(x_coord), H - 1);
    check("fullline_y", int'(y_coord), 0);
    check("fullline_pix", int'(pixel_data), 8'h7F);
    drive_line(8, 0, 0, 0);
    drain("drain_fullline");
    check("line1_y", int'(y_coord), 1);

    // Overlong line: column saturates, data freezes at the last in-range pixel.
    vsync_pulse();
    drive_line(1400, 0, 0, 0);
    drain("drain_longline");
    check("longline_x", int'(x_coord), H - 1);
    check("longline_pix", int'(pixel_data), lp);

    // Too many lines: row saturates.
    vsync_pulse();
    for (int l = 0; l < V + 2; l++) drive_line(4, 0, 0, 0);
    drain("drain_rows");
    check("rows_y", int'(y_coord), V - 1);
    check("rows_x", int'(x_coord), 1);
    check("rows_model_y", int'(y_coord), ly);

    // vsync raised mid-line 10, next frame restarts at (0,0).
    vsync_pulse();
    for (int l = 0; l < 10; l++) drive_line(8, 0, 0, 0);
    drive_line(40, 0, 1, 20);
    drive_line(8, 0, 0, 0);
    drain("drain_vsync_cut");
    check("vsync_cut_y", int'(y_coord), 0);

    // config_done dropped mid-line 10: nothing until config and a full vsync pulse.
    vsync_pulse();
    for (int l = 0; l < 10; l++) drive_line(8, 0, 0, 0);
    drive_line(40, 0, 2, 21);
    drive_line(8, 0, 0, 0);
    set_config(1'b1);
    drive_line(8, 0, 0, 0);
    vsync_pulse();
    drive_line(8, 0, 0, 0);
    drain("drain_cfg_cut");
    check("cfg_cut_y", int'(y_coord), 0);

    // Reset mid-line: outputs clear, capture resumes after a vsync fall.
    vsync_pulse();
    drive_line(8, 0, 0, 0);
    drive_line(40, 0, 3, 15);
    drive_line(8, 0, 0, 0);
    vsync_pulse();
    drive_line(8, 0, 0, 0);
    drain("drain_reset_cut");
    check("reset_cut_x", int'(x_coord), lx);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
